// File: rtl/soc_reset_sequencer_if.sv
// Pin bundle between the board/clocking side and the SoC reset sequencer.
// The master drives the raw board pins; the slave is the sequencer itself.
interface soc_reset_sequencer_if;
    logic       btn_reset_i;
    logic       clk_locked_i;
    logic       bootsel_i;
    logic       monitor_alert_i;
    logic       soc_rst_no;
    logic       bootsel_o;
    logic [1:0] rst_cause_o;
    logic [7:0] rst_count_o;
    logic       busy_o;

    modport master (
        output btn_reset_i, clk_locked_i, bootsel_i, monitor_alert_i,
        input  soc_rst_no, bootsel_o, rst_cause_o, rst_count_o, busy_o
    );

    modport slave (
        input  btn_reset_i, clk_locked_i, bootsel_i, monitor_alert_i,
        output soc_rst_no, bootsel_o, rst_cause_o, rst_count_o, busy_o
    );
endinterface

// File: rtl/soc_reset_sequencer.sv
// SoC reset sequencer: button debounce, lock wait, hold timer, bootsel latch, reset-cause log.
// Build option: define MONITOR_ALERT_RESET_EN to let monitor_alert_i warm-reset the SoC from RUN.
module soc_reset_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 64,
    parameter int BOOTSEL_SETUP   = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    soc_reset_sequencer_if.slave        bus
);

    // state     | meaning
    // ----------+--------------------------------------------------
    // WAIT_LOCK | SoC in reset, waiting for lock and button release
    // HOLD      | lock present, reset hold timer running
    // SAMPLE    | bootsel setup window, latch on last cycle
    // RUN       | SoC released from reset

    localparam int TMAX = (HOLD_CYCLES > BOOTSEL_SETUP) ? HOLD_CYCLES : BOOTSEL_SETUP;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        SAMPLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_btn_s1;
    logic            r_btn_s2;
    logic            r_btn_deb;
    logic            r_btn_deb_q;
    logic [DW-1:0]   r_deb_cnt;
    logic            r_bs_s1;
    logic            r_bs_s2;
    logic [TW-1:0]   r_tmr;
    logic            r_soc_rst_n;
    logic            r_bootsel;
    logic            r_busy;
    logic [1:0]      r_cause;
    logic [7:0]      r_count;

    logic            w_btn_rise;
    logic            w_alert;
    logic            w_exit;
    logic            w_latch;
    logic [1:0]      w_cause_nxt;

`ifdef MONITOR_ALERT_RESET_EN
    assign w_alert = bus.monitor_alert_i;
`else
    assign w_alert = 1'b0;
`endif

    assign w_btn_rise = r_btn_deb & ~r_btn_deb_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_btn_s1    <= 1'b0;
            r_btn_s2    <= 1'b0;
            r_btn_deb   <= 1'b0;
            r_btn_deb_q <= 1'b0;
            r_deb_cnt   <= '0;
            r_bs_s1     <= 1'b0;
            r_bs_s2     <= 1'b0;
        end else begin
            r_btn_s1    <= bus.btn_reset_i;
            r_btn_s2    <= r_btn_s1;
            r_btn_deb_q <= r_btn_deb;
            r_bs_s1     <= bus.bootsel_i;
            r_bs_s2     <= r_bs_s1;
            // Level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples
            if (r_btn_s2 == r_btn_deb) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                r_btn_deb <= ~r_btn_deb;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_exit      = 1'b0;
        w_latch     = 1'b0;
        w_cause_nxt = r_cause;
        case (r_state)
            WAIT_LOCK: begin
                if (bus.clk_locked_i && !r_btn_deb) w_state_nxt = HOLD;
            end
            HOLD: begin
                if (!bus.clk_locked_i || r_btn_deb)          w_state_nxt = WAIT_LOCK;
                else if (r_tmr == TW'(HOLD_CYCLES - 1))      w_state_nxt = SAMPLE;
            end
            SAMPLE: begin
                if (!bus.clk_locked_i) begin
                    w_state_nxt = WAIT_LOCK;
                end else if (r_tmr == TW'(BOOTSEL_SETUP - 1)) begin
                    w_latch     = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!bus.clk_locked_i) begin
                    w_state_nxt = WAIT_LOCK;
                    w_exit      = 1'b1;
                    w_cause_nxt = 2'b11;
                end else if (w_btn_rise) begin
                    w_state_nxt = WAIT_LOCK;
                    w_exit      = 1'b1;
                    w_cause_nxt = 2'b01;
                end else if (w_alert) begin
                    w_state_nxt = HOLD;
                    w_exit      = 1'b1;
                    w_cause_nxt = 2'b10;
                end
            end
            default: w_state_nxt = WAIT_LOCK;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= WAIT_LOCK;
            r_tmr       <= '0;
            r_soc_rst_n <= 1'b0;
            r_busy      <= 1'b1;
            r_bootsel   <= 1'b0;
            r_cause     <= 2'b00;
            r_count     <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state || r_state == WAIT_LOCK || r_state == RUN) begin
                r_tmr <= '0;
            end else begin
                r_tmr <= r_tmr + 1'b1;
            end
            // Outputs follow the next state so they change in the first cycle of that state
            r_soc_rst_n <= (w_state_nxt == RUN);
            r_busy      <= (w_state_nxt != RUN);
            if (w_latch) r_bootsel <= r_bs_s2;
            if (w_exit) begin
                r_cause <= w_cause_nxt;
                if (r_count != 8'hFF) r_count <= r_count + 8'd1;
            end
        end
    end

    assign bus.soc_rst_no  = r_soc_rst_n;
    assign bus.bootsel_o   = r_bootsel;
    assign bus.rst_cause_o = r_cause;
    assign bus.rst_count_o = r_count;
    assign bus.busy_o      = r_busy;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Scoreboard bench for soc_reset_sequencer: stimulus pushes expected reset edges,
// a negedge monitor pops and checks them when soc_rst_no changes.
module tb_soc_reset_sequencer;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    soc_reset_sequencer_if bus_if();

    soc_reset_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (8),
        .BOOTSEL_SETUP  (2)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference latencies with DEBOUNCE=4, HOLD=8, SETUP=2:
    //   lock/rst release seen at edge c+1 -> HOLD entry, RUN 10 edges later
    //   button press driven at c -> debounced rise evaluated at edge c+7
    //   button release driven at r -> WAIT_LOCK leaves at edge r+7
    localparam int LAT = 10;

    typedef struct {
        bit         rise;
        int         at;
        logic [1:0] cause;
        logic [7:0] count;
        logic       bs;
    } exp_t;

    exp_t       q[$];
    logic [1:0] m_cause;
    int         m_count;
    logic       m_bs;
    logic       cur_bs;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic push_rise(input int at, input logic bs);
        exp_t e;
        e.rise = 1'b1; e.at = at; e.cause = m_cause; e.count = 8'(m_count); e.bs = bs;
        m_bs = bs;
        q.push_back(e);
    endtask

    task automatic push_fall(input int at, input logic [1:0] cause);
        exp_t e;
        m_cause = cause;
        m_count = (m_count >= 255) ? 255 : m_count + 1;
        e.rise = 1'b0; e.at = at; e.cause = m_cause; e.count = 8'(m_count); e.bs = m_bs;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_pending", q.size(), 0);
        q.delete();
    endtask

    // Monitor
    initial begin
        logic prev_n;
        exp_t e;
        prev_n = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.soc_rst_no !== prev_n) begin
                if (q.size() == 0) begin
                    chk("unexpected_edge_rst_n", int'(bus_if.soc_rst_no), int'(prev_n));
                end else begin
                    e = q.pop_front();
                    chk("edge_dir",  int'(bus_if.soc_rst_no),  int'(e.rise));
                    chk("edge_cyc",  cyc,                      e.at);
                    chk("cause",     int'(bus_if.rst_cause_o), int'(e.cause));
                    chk("count",     int'(bus_if.rst_count_o), int'(e.count));
                    chk("busy",      int'(bus_if.busy_o),      int'(!e.rise));
                    chk("bootsel",   int'(bus_if.bootsel_o),   int'(e.bs));
                end
            end
            prev_n = bus_if.soc_rst_no;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, r, l, g, p, entry, cnt0;
        rst = 1'b1;
        bus_if.btn_reset_i     = 1'b0;
        bus_if.clk_locked_i    = 1'b1;
        bus_if.bootsel_i       = 1'b1;
        bus_if.monitor_alert_i = 1'b0;
        cur_bs  = 1'b1;
        m_cause = 2'b00;
        m_count = 0;
        m_bs    = 1'b0;
        tick(3);

        // 1. reset values, then POR sequence
        chk("rst_soc_rst_no", int'(bus_if.soc_rst_no),  0);
        chk("rst_bootsel",    int'(bus_if.bootsel_o),   0);
        chk("rst_busy",       int'(bus_if.busy_o),      1);
        chk("rst_cause",      int'(bus_if.rst_cause_o), 0);
        chk("rst_count",      int'(bus_if.rst_count_o), 0);
        c = cyc;
        push_rise(c + 1 + LAT, 1'b1);
        rst = 1'b0;
        drain(40);

        // 2. lock loss in RUN, late lock, then a 1-cycle dropout at HOLD count 5
        tick(3 + $urandom_range(0, 5));
        c = cyc;
        push_fall(c + 1, 2'b11);
        bus_if.clk_locked_i = 1'b0;
        tick(50 + $urandom_range(0, 9));
        c = cyc;
        bus_if.clk_locked_i = 1'b1;
        tick(6);
        bus_if.clk_locked_i = 1'b0;
        tick(1);
        bus_if.clk_locked_i = 1'b1;
        push_rise(cyc + 1 + LAT, cur_bs);
        drain(40);

        // 3. short glitch ignored, long press resets, bootsel re-latched as 0
        tick(5);
        g = $urandom_range(1, 3);
        bus_if.btn_reset_i = 1'b1;
        tick(g);
        bus_if.btn_reset_i = 1'b0;
        tick(15);
        chk("glitch_soc_rst_no", int'(bus_if.soc_rst_no),  1);
        chk("glitch_count",      int'(bus_if.rst_count_o), m_count);
        bus_if.bootsel_i = 1'b0;
        cur_bs = 1'b0;
        tick(3);
        c = cyc;
        push_fall(c + 7, 2'b01);
        bus_if.btn_reset_i = 1'b1;
        tick(20);
        bus_if.btn_reset_i = 1'b0;
        r = cyc;
        push_rise(r + 7 + LAT, cur_bs);
        drain(60);

        // 4. lock loss coincides with debounced button rise
        cur_bs = 1'($urandom_range(0, 1));
        bus_if.bootsel_i = cur_bs;
        tick(4);
        c = cyc;
        push_fall(c + 7, 2'b11);
        bus_if.btn_reset_i = 1'b1;
        tick(6);
        bus_if.clk_locked_i = 1'b0;
        tick(1);
        bus_if.btn_reset_i = 1'b0;
        r = cyc;
        tick(5 + $urandom_range(0, 19));
        bus_if.clk_locked_i = 1'b1;
        l = cyc;
        entry = (l + 1 > r + 7) ? l + 1 : r + 7;
        push_rise(entry + LAT, cur_bs);
        drain(60);

        // 5. monitor alert
        tick(4);
`ifdef MONITOR_ALERT_RESET_EN
        c = cyc;
        push_fall(c + 1, 2'b10);
        push_rise(c + 1 + LAT, cur_bs);
        bus_if.monitor_alert_i = 1'b1;
        tick(1);
        bus_if.monitor_alert_i = 1'b0;
        drain(40);
`else
        cnt0 = m_count;
        bus_if.monitor_alert_i = 1'b1;
        tick(1);
        bus_if.monitor_alert_i = 1'b0;
        tick(15);
        chk("alert_off_soc_rst_no", int'(bus_if.soc_rst_no),  1);
        chk("alert_off_count",      int'(bus_if.rst_count_o), cnt0);
`endif

        // 6. counter saturation through repeated button resets
        for (int i = 0; i < 260; i++) begin
            cur_bs = 1'($urandom_range(0, 1));
            bus_if.bootsel_i = cur_bs;
            c = cyc;
            push_fall(c + 7, 2'b01);
            bus_if.btn_reset_i = 1'b1;
            p = $urandom_range(5, 9);
            tick(p);
            bus_if.btn_reset_i = 1'b0;
            r = cyc;
            push_rise(r + 7 + LAT, cur_bs);
            drain(60);
        end
        chk("sat_count", int'(bus_if.rst_count_o), 255);

        // async reset mid-HOLD, checked between clock edges
        c = cyc;
        push_fall(c + 1, 2'b11);
        bus_if.clk_locked_i = 1'b0;
        tick(2);
        bus_if.clk_locked_i = 1'b1;
        tick(3);
        chk("pre_async_queue", q.size(), 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_soc_rst_no", int'(bus_if.soc_rst_no),  0);
        chk("async_bootsel",    int'(bus_if.bootsel_o),   0);
        chk("async_busy",       int'(bus_if.busy_o),      1);
        chk("async_cause",      int'(bus_if.rst_cause_o), 0);
        chk("async_count",      int'(bus_if.rst_count_o), 0);
        m_cause = 2'b00;
        m_count = 0;
        m_bs    = 1'b0;
        tick(2);
        cur_bs = 1'($urandom_range(0, 1));
        bus_if.bootsel_i = cur_bs;
        tick(3);
        c = cyc;
        push_rise(c + 1 + LAT, cur_bs);
        rst = 1'b0;
        drain(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
